mem_ctrl: RTL and testbench

Byte-wide memory controller between the core and the single-port synchronous RAM. It serves two requesters: byte-at-a-time instruction reads from the instruction cache (IC), and 1/2/4-byte loads and stores from the load/store buffer (LS). It holds one pending request per requester and arbitrates between them with LS priority. Multi-byte accesses are sequenced into pipelined per-byte RAM cycles.

---
 rtl/mem_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller arbitrating IC byte reads and LS 1/2/4-byte loads/stores (LS priority).
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        iIC_En,
  input  logic [31:0] iIC_Add,
  output logic        oIC_En,
  output logic [7:0]  oIC_Dat,
  input  logic        iLS_En,
  input  logic        iLS_Wr,
  input  logic [2:0]  iLS_Len,
  input  logic [31:0] iLS_Add,
  input  logic [31:0] iLS_Dat,
  output logic        oLS_En,
  output logic [31:0] oLS_Dat,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {IDLE, IC_RD, LS_RD, LS_WR} state_t;
  state_t      r_st;
  logic        r_ic_v, r_ls_v, r_ls_wr;
  logic [31:0] r_ic_add, r_ls_add, r_ls_dat, r_add, r_dat;
  logic [2:0]  r_ls_len, r_len, r_k;
  // A request arriving on the dispatch edge is served straight from the inputs.
  logic        w_ic_p, w_ls_p, w_ls_wr, w_stall;
  logic [31:0] w_ic_add, w_ls_add, w_ls_dat, w_a;
  logic [2:0]  w_ls_len, w_j2;
  assign w_ic_p   = r_ic_v | iIC_En;
  assign w_ls_p   = r_ls_v | iLS_En;
  assign w_ic_add = r_ic_v ? r_ic_add : iIC_Add;
  assign w_ls_wr  = r_ls_v ? r_ls_wr  : iLS_Wr;
  assign w_ls_len = r_ls_v ? r_ls_len : iLS_Len;
  assign w_ls_add = r_ls_v ? r_ls_add : iLS_Add;
  assign w_ls_dat = r_ls_v ? r_ls_dat : iLS_Dat;
  assign w_a      = r_add + {29'd0, r_k};
  assign w_stall  = io_buffer_full && (w_a[17:16] == IO_HI);
  assign w_j2     = r_k - 3'd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      r_ic_v <= 1'b0;
      r_ls_v <= 1'b0;
      r_ls_wr <= 1'b0;
      r_ic_add <= '0;
      r_ls_add <= '0;
      r_ls_dat <= '0;
      r_ls_len <= '0;
      r_add <= '0;
      r_dat <= '0;
      r_len <= '0;
      r_k <= '0;
      oIC_En <= 1'b0;
      oIC_Dat <= '0;
      oLS_En <= 1'b0;
      oLS_Dat <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
    end else if (!en) begin
      oIC_En <= 1'b0;
      oLS_En <= 1'b0;
      mem_wr <= 1'b0;
    end else begin
      oIC_En <= 1'b0;
      oLS_En <= 1'b0;
      mem_wr <= 1'b0;
      if (iIC_En) begin
        r_ic_v <= 1'b1;
        r_ic_add <= iIC_Add;
      end
      if (iLS_En) begin
        r_ls_v <= 1'b1;
        r_ls_wr <= iLS_Wr;
        r_ls_len <= iLS_Len;
        r_ls_add <= iLS_Add;
        r_ls_dat <= iLS_Dat;
      end
      case (r_st)
        IDLE: begin
          r_k <= '0;
          if (w_ls_p) begin
            r_ls_v <= 1'b0;
            r_st <= w_ls_wr ? LS_WR : LS_RD;
            r_add <= w_ls_add;
            r_len <= w_ls_len;
            r_dat <= w_ls_dat;
            if (!w_ls_wr) oLS_Dat <= '0;
          end else if (w_ic_p) begin
            r_ic_v <= 1'b0;
            mem_a <= w_ic_add;
            r_st <= IC_RD;
          end
        end
        IC_RD: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd1) begin
            oIC_Dat <= mem_din;
            oIC_En <= 1'b1;
            r_st <= IDLE;
          end
        end
        LS_RD: begin
          r_k <= r_k + 3'd1;
          if (r_k < r_len) mem_a <= w_a;
          if (r_k >= 3'd2) oLS_Dat[{w_j2[1:0], 3'b000} +: 8] <= mem_din;
          if (r_k == r_len + 3'd1) begin
            oLS_En <= 1'b1;
            r_st <= IDLE;
          end
        end
        LS_WR: begin
          if (r_k == r_len) begin
            oLS_En <= 1'b1;
            r_st <= IDLE;
          end else if (!w_stall) begin
            mem_a <= w_a;
            mem_dout <= r_dat[7:0];
            r_dat <= r_dat >> 8;
            mem_wr <= 1'b1;
            r_k <= r_k + 3'd1;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte RAM model with hand-computed expectations.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic        iIC_En = 1'b0, iLS_En = 1'b0, iLS_Wr = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] iIC_Add = '0, iLS_Add = '0, iLS_Dat = '0;
  logic [2:0]  iLS_Len = 3'd1;
  logic        oIC_En, oLS_En, mem_wr;
  logic [7:0]  oIC_Dat, mem_din, mem_dout;
  logic [31:0] oLS_Dat, mem_a;
  logic [7:0]  ram [0:4095];
  int          checks = 0, failures = 0;
  logic        wr_any = 1'b0, ls_any = 1'b0;
  mem_ctrl #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .en(en),
    .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
    .iLS_En(iLS_En), .iLS_Wr(iLS_Wr), .iLS_Len(iLS_Len), .iLS_Add(iLS_Add), .iLS_Dat(iLS_Dat),
    .oLS_En(oLS_En), .oLS_Dat(oLS_Dat),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    wr_any = wr_any | mem_wr;
    ls_any = ls_any | oLS_En;
  endtask
  task automatic ls_req(input logic wr, input logic [2:0] len, input logic [31:0] add, input logic [31:0] dat);
    iLS_En = 1'b1; iLS_Wr = wr; iLS_Len = len; iLS_Add = add; iLS_Dat = dat;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h6C; ram[12'h400] = 8'h5A;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
    step; step;
    chk("rst_ic_en", {31'd0, oIC_En}, 0);
    chk("rst_ic_dat", {24'd0, oIC_Dat}, 0);
    chk("rst_ls_en", {31'd0, oLS_En}, 0);
    chk("rst_ls_dat", oLS_Dat, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 0);
    rst = 1'b0;
    step;
    // IC read at 0x100
    wr_any = 1'b0;
    iIC_En = 1'b1; iIC_Add = 32'h100;
    step;
    iIC_En = 1'b0;
    chk("ic_a", mem_a, 32'h100);
    for (int c = 1; c <= 3; c++) begin
      step;
      chk($sformatf("ic_en_c%0d", c), {31'd0, oIC_En}, {31'd0, c == 2});
      if (c == 2) chk("ic_dat", {24'd0, oIC_Dat}, 32'h13);
    end
    chk("ic_no_wr", {31'd0, wr_any}, 0);
    // 4-byte load at 0x200
    ls_req(1'b0, 3'd4, 32'h200, 0);
    step;
    iLS_En = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step;
      if (c <= 4) chk($sformatf("ld4_a_c%0d", c), mem_a, 32'h200 + c - 1);
      chk($sformatf("ld4_en_c%0d", c), {31'd0, oLS_En}, {31'd0, c == 6});
      if (c == 6) chk("ld4_dat", oLS_Dat, 32'h44332211);
    end
    // 2-byte store 0xBEEF at 0x300, then byte readback at 0x301
    ls_req(1'b1, 3'd2, 32'h300, 32'h0000BEEF);
    step;
    iLS_En = 1'b0;
    step;
    chk("st_wr_c1", {31'd0, mem_wr}, 1);
    chk("st_a_c1", mem_a, 32'h300);
    chk("st_d_c1", {24'd0, mem_dout}, 32'hEF);
    step;
    chk("st_wr_c2", {31'd0, mem_wr}, 1);
    chk("st_a_c2", mem_a, 32'h301);
    chk("st_d_c2", {24'd0, mem_dout}, 32'hBE);
    chk("st_en_c2", {31'd0, oLS_En}, 0);
    step;
    chk("st_wr_c3", {31'd0, mem_wr}, 0);
    chk("st_en_c3", {31'd0, oLS_En}, 1);
    step;
    ls_req(1'b0, 3'd1, 32'h301, 0);
    step;
    iLS_En = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step;
      chk($sformatf("rb_en_c%0d", c), {31'd0, oLS_En}, {31'd0, c == 3});
    end
    chk("rb_dat", oLS_Dat, 32'h000000BE);
    step;
    // IC and 2-byte LS load in the same cycle: LS first, IC after
    iIC_En = 1'b1; iIC_Add = 32'h400;
    ls_req(1'b0, 3'd2, 32'h200, 0);
    step;
    iIC_En = 1'b0; iLS_En = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 4) begin
        chk("arb_ls_en", {31'd0, oLS_En}, 1);
        chk("arb_ls_dat", oLS_Dat, 32'h00002211);
        chk("arb_ic_late", {31'd0, oIC_En}, 0);
      end
      if (c == 5) chk("arb_ic_a", mem_a, 32'h400);
      if (c == 7) begin
        chk("arb_ic_en", {31'd0, oIC_En}, 1);
        chk("arb_ic_dat", {24'd0, oIC_Dat}, 32'h5A);
      end
    end
    // 1-byte I/O store stalled 3 cycles by a full buffer
    io_buffer_full = 1'b1;
    ls_req(1'b1, 3'd1, 32'h30000, 32'h77);
    step;
    iLS_En = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step;
      chk($sformatf("io_wr_c%0d", c), {31'd0, mem_wr}, {31'd0, c == 4});
      chk($sformatf("io_en_c%0d", c), {31'd0, oLS_En}, {31'd0, c == 5});
      if (c == 4) begin
        chk("io_a", mem_a, 32'h30000);
        chk("io_d", {24'd0, mem_dout}, 32'h77);
      end
      if (c == 3) io_buffer_full = 1'b0;
    end
    // en=0 freezes an IC read for two edges
    iIC_En = 1'b1; iIC_Add = 32'h101;
    step;
    iIC_En = 1'b0;
    en = 1'b0;
    step; step;
    chk("en_hold_ic", {31'd0, oIC_En}, 0);
    en = 1'b1;
    step;
    chk("en_c3_ic", {31'd0, oIC_En}, 0);
    step;
    chk("en_c4_ic", {31'd0, oIC_En}, 1);
    chk("en_ic_dat", {24'd0, oIC_Dat}, 32'h6C);
    step;
    // reset in the middle of a 4-byte load
    ls_req(1'b0, 3'd4, 32'h200, 0);
    step;
    iLS_En = 1'b0;
    step; step; step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mrst_ls_dat", oLS_Dat, 0);
    chk("mrst_mem_a", mem_a, 0);
    chk("mrst_ic_dat", {24'd0, oIC_Dat}, 0);
    chk("mrst_ls_en", {31'd0, oLS_En}, 0);
    ls_any = 1'b0;
    step; step; step; step;
    chk("mrst_no_ls_en", {31'd0, ls_any}, 0);
    iIC_En = 1'b1; iIC_Add = 32'h100;
    step;
    iIC_En = 1'b0;
    step; step;
    chk("post_rst_ic_en", {31'd0, oIC_En}, 1);
    chk("post_rst_ic_dat", {24'd0, oIC_Dat}, 32'h13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
